// File: rtl/ahbl_arbiter_pkg.sv
// Shared AHB-lite definitions for the arbiter and splitter.
package ahbl_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

endpackage

// File: rtl/ahbl_arbiter_onehot_priority.sv
// N-bit fixed-priority picker: the lowest-index set request wins.
module onehot_priority #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 arbiter with a one-transfer address-phase buffer per upstream port.
module ahbl_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          ahbls_hready,
  output logic [N_PORTS-1:0]          ahbls_hready_resp,
  output logic [N_PORTS-1:0]          ahbls_hresp,
  input  logic [N_PORTS*W_ADDR-1:0]   ahbls_haddr,
  input  logic [N_PORTS-1:0]          ahbls_hwrite,
  input  logic [N_PORTS*2-1:0]        ahbls_htrans,
  input  logic [N_PORTS*3-1:0]        ahbls_hsize,
  input  logic [N_PORTS*3-1:0]        ahbls_hburst,
  input  logic [N_PORTS*4-1:0]        ahbls_hprot,
  input  logic [N_PORTS-1:0]          ahbls_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0]   ahbls_hwdata,
  output logic [N_PORTS*W_DATA-1:0]   ahbls_hrdata,
  output logic                        ahblm_hready,
  input  logic                        ahblm_hready_resp,
  input  logic                        ahblm_hresp,
  output logic [W_ADDR-1:0]           ahblm_haddr,
  output logic                        ahblm_hwrite,
  output logic [1:0]                  ahblm_htrans,
  output logic [2:0]                  ahblm_hsize,
  output logic [2:0]                  ahblm_hburst,
  output logic [3:0]                  ahblm_hprot,
  output logic                        ahblm_hmastlock,
  output logic [W_DATA-1:0]           ahblm_hwdata,
  input  logic [W_DATA-1:0]           ahblm_hrdata
);

  import ahbl_arbiter_pkg::*;

  logic [N_PORTS-1:0] buf_valid, live, req, pri_grant, grant_a, grant_d, hold_grant, accept;
  logic               hold_valid;

  logic [W_ADDR-1:0]  buf_addr  [N_PORTS];
  logic               buf_write [N_PORTS];
  logic [1:0]         buf_trans [N_PORTS];
  logic [2:0]         buf_size  [N_PORTS];
  logic [2:0]         buf_burst [N_PORTS];
  logic [3:0]         buf_prot  [N_PORTS];
  logic               buf_lock  [N_PORTS];

  htrans_t            m_trans;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign live[g]              = ahbls_hready[g] && ahbls_htrans[2*g+1] && !buf_valid[g];
    assign ahbls_hready_resp[g] = grant_d[g] ? ahblm_hready_resp : !buf_valid[g];
    assign ahbls_hresp[g]       = grant_d[g] & ahblm_hresp;
    assign ahbls_hrdata[g*W_DATA +: W_DATA] = ahblm_hrdata;
  end

  assign req = buf_valid | live;

  onehot_priority #(.W(N_PORTS)) u_priority (
    .req (req),
    .gnt (pri_grant)
  );

  // A stalled address phase keeps its owner even if a higher-priority request shows up.
  assign grant_a      = hold_valid ? hold_grant : pri_grant;
  assign ahblm_hready = ahblm_hready_resp;
  assign accept       = grant_a & {N_PORTS{ahblm_hready}};
  assign ahblm_htrans = m_trans;

  always_comb begin
    ahblm_haddr     = '0;
    ahblm_hwrite    = 1'b0;
    m_trans         = HTRANS_IDLE;
    ahblm_hsize     = '0;
    ahblm_hburst    = '0;
    ahblm_hprot     = '0;
    ahblm_hmastlock = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant_a[i]) begin
        if (buf_valid[i]) begin
          ahblm_haddr     = buf_addr[i];
          ahblm_hwrite    = buf_write[i];
          m_trans         = htrans_t'(buf_trans[i]);
          ahblm_hsize     = buf_size[i];
          ahblm_hburst    = buf_burst[i];
          ahblm_hprot     = buf_prot[i];
          ahblm_hmastlock = buf_lock[i];
        end else begin
          ahblm_haddr     = ahbls_haddr[i*W_ADDR +: W_ADDR];
          ahblm_hwrite    = ahbls_hwrite[i];
          m_trans         = htrans_t'(ahbls_htrans[i*2 +: 2]);
          ahblm_hsize     = ahbls_hsize[i*3 +: 3];
          ahblm_hburst    = ahbls_hburst[i*3 +: 3];
          ahblm_hprot     = ahbls_hprot[i*4 +: 4];
          ahblm_hmastlock = ahbls_hmastlock[i];
        end
      end
    end
  end

  always_comb begin
    ahblm_hwdata = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant_d[i]) ahblm_hwdata = ahblm_hwdata | ahbls_hwdata[i*W_DATA +: W_DATA];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid  <= '0;
      hold_valid <= 1'b0;
      hold_grant <= '0;
      grant_d    <= '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        buf_addr[i]  <= '0;
        buf_write[i] <= 1'b0;
        buf_trans[i] <= '0;
        buf_size[i]  <= '0;
        buf_burst[i] <= '0;
        buf_prot[i]  <= '0;
        buf_lock[i]  <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (live[i] && !accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_addr[i]  <= ahbls_haddr[i*W_ADDR +: W_ADDR];
          buf_write[i] <= ahbls_hwrite[i];
          buf_trans[i] <= ahbls_htrans[i*2 +: 2];
          buf_size[i]  <= ahbls_hsize[i*3 +: 3];
          buf_burst[i] <= ahbls_hburst[i*3 +: 3];
          buf_prot[i]  <= ahbls_hprot[i*4 +: 4];
          buf_lock[i]  <= ahbls_hmastlock[i];
        end else if (buf_valid[i] && accept[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (ahblm_hready) begin
        hold_valid <= 1'b0;
        grant_d    <= grant_a;
      end else if (|grant_a) begin
        hold_valid <= 1'b1;
        hold_grant <= grant_a;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed self-checking bench for ahbl_arbiter with two upstream ports.
module tb_ahbl_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned WA = 32;
  localparam int unsigned WD = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_hready;
  logic [N-1:0]    s_hready_resp;
  logic [N-1:0]    s_hresp;
  logic [N*WA-1:0] s_haddr;
  logic [N-1:0]    s_hwrite;
  logic [N*2-1:0]  s_htrans;
  logic [N*3-1:0]  s_hsize;
  logic [N*3-1:0]  s_hburst;
  logic [N*4-1:0]  s_hprot;
  logic [N-1:0]    s_hmastlock;
  logic [N*WD-1:0] s_hwdata;
  logic [N*WD-1:0] s_hrdata;
  logic            m_hready;
  logic            m_hready_resp;
  logic            m_hresp;
  logic [WA-1:0]   m_haddr;
  logic            m_hwrite;
  logic [1:0]      m_htrans;
  logic [2:0]      m_hsize;
  logic [2:0]      m_hburst;
  logic [3:0]      m_hprot;
  logic            m_hmastlock;
  logic [WD-1:0]   m_hwdata;
  logic [WD-1:0]   m_hrdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready      (s_hready),
    .ahbls_hready_resp (s_hready_resp),
    .ahbls_hresp       (s_hresp),
    .ahbls_haddr       (s_haddr),
    .ahbls_hwrite      (s_hwrite),
    .ahbls_htrans      (s_htrans),
    .ahbls_hsize       (s_hsize),
    .ahbls_hburst      (s_hburst),
    .ahbls_hprot       (s_hprot),
    .ahbls_hmastlock   (s_hmastlock),
    .ahbls_hwdata      (s_hwdata),
    .ahbls_hrdata      (s_hrdata),
    .ahblm_hready      (m_hready),
    .ahblm_hready_resp (m_hready_resp),
    .ahblm_hresp       (m_hresp),
    .ahblm_haddr       (m_haddr),
    .ahblm_hwrite      (m_hwrite),
    .ahblm_htrans      (m_htrans),
    .ahblm_hsize       (m_hsize),
    .ahblm_hburst      (m_hburst),
    .ahblm_hprot       (m_hprot),
    .ahblm_hmastlock   (m_hmastlock),
    .ahblm_hwdata      (m_hwdata),
    .ahblm_hrdata      (m_hrdata)
  );

  task automatic set_port(input int p, input logic [1:0] tr, input logic [31:0] a,
                          input logic wr, input logic rdy);
    s_htrans[p*2 +: 2] = tr;
    s_haddr[p*WA +: WA] = a;
    s_hwrite[p]         = wr;
    s_hready[p]         = rdy;
  endtask

  // Advance one clock; inputs are then driven 1 ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_hready = '1; s_haddr = '0; s_hwrite = '0; s_htrans = '0;
    s_hsize = '0; s_hburst = '0; s_hprot = '0; s_hmastlock = '0; s_hwdata = '0;
    m_hready_resp = 1'b1; m_hresp = 1'b0; m_hrdata = '0;
    next_cycle(); next_cycle();
    #2;
    checks++; if (m_htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b expected 00", m_htrans); end
    checks++; if (s_hready_resp !== 2'b11) begin errors++; $display("FAIL reset_hready_resp: got %b expected 11", s_hready_resp); end
    checks++; if (s_hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b expected 00", s_hresp); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_uncontended();
    set_port(0, 2'b10, 32'h100, 1'b0, 1'b1);
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    #2;
    checks++; if (m_htrans !== 2'b10) begin errors++; $display("FAIL uncont_htrans: got %b expected 10", m_htrans); end
    checks++; if (m_haddr !== 32'h100) begin errors++; $display("FAIL uncont_haddr: got %h expected 00000100", m_haddr); end
    next_cycle();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    m_hrdata = 32'hcafe0001;
    #2;
    checks++; if (s_hrdata[31:0] !== 32'hcafe0001) begin errors++; $display("FAIL uncont_hrdata: got %h expected cafe0001", s_hrdata[31:0]); end
    checks++; if (s_hready_resp[0] !== 1'b1) begin errors++; $display("FAIL uncont_rdy_hi: got %b expected 1", s_hready_resp[0]); end
    m_hready_resp = 1'b0;
    #1;
    checks++; if (s_hready_resp[0] !== 1'b0) begin errors++; $display("FAIL uncont_rdy_lo: got %b expected 0", s_hready_resp[0]); end
    next_cycle();
    m_hready_resp = 1'b1;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    set_port(0, 2'b10, 32'h10, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h20, 1'b0, 1'b1);
    #2;
    checks++; if (m_haddr !== 32'h10) begin errors++; $display("FAIL sim_c0_haddr: got %h expected 00000010", m_haddr); end
    next_cycle();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h20, 1'b0, 1'b0);
    #2;
    checks++; if (m_haddr !== 32'h20 || m_htrans !== 2'b10) begin errors++; $display("FAIL sim_c1_addr: got %h/%b expected 00000020/10", m_haddr, m_htrans); end
    checks++; if (s_hready_resp[1] !== 1'b0) begin errors++; $display("FAIL sim_c1_rdy1: got %b expected 0", s_hready_resp[1]); end
    next_cycle();
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    #2;
    checks++; if (m_htrans !== 2'b00) begin errors++; $display("FAIL sim_c2_htrans: got %b expected 00", m_htrans); end
    checks++; if (s_hready_resp[1] !== 1'b1) begin errors++; $display("FAIL sim_c2_rdy1_hi: got %b expected 1", s_hready_resp[1]); end
    m_hready_resp = 1'b0;
    #1;
    checks++; if (s_hready_resp[1] !== 1'b0) begin errors++; $display("FAIL sim_c2_rdy1_lo: got %b expected 0", s_hready_resp[1]); end
    next_cycle();
    m_hready_resp = 1'b1;
    next_cycle();
  endtask

  task automatic test_stall();
    m_hready_resp = 1'b0;
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h40, 1'b0, 1'b1);
    #2;
    checks++; if (m_haddr !== 32'h40 || m_htrans !== 2'b10) begin errors++; $display("FAIL stall_c0: got %h/%b expected 00000040/10", m_haddr, m_htrans); end
    next_cycle();
    set_port(0, 2'b10, 32'h80, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h40, 1'b0, 1'b0);
    #2;
    checks++; if (m_haddr !== 32'h40) begin errors++; $display("FAIL stall_c1_haddr: got %h expected 00000040", m_haddr); end
    next_cycle();
    set_port(0, 2'b10, 32'h80, 1'b0, 1'b0);
    #2;
    checks++; if (m_haddr !== 32'h40) begin errors++; $display("FAIL stall_c2_haddr: got %h expected 00000040", m_haddr); end
    next_cycle();
    m_hready_resp = 1'b1;
    #2;
    checks++; if (m_haddr !== 32'h40 || m_htrans !== 2'b10) begin errors++; $display("FAIL stall_c3: got %h/%b expected 00000040/10", m_haddr, m_htrans); end
    next_cycle();
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    #2;
    checks++; if (m_haddr !== 32'h80 || m_htrans !== 2'b10) begin errors++; $display("FAIL stall_c4: got %h/%b expected 00000080/10", m_haddr, m_htrans); end
    checks++; if (s_hready_resp[0] !== 1'b0) begin errors++; $display("FAIL stall_c4_rdy0: got %b expected 0", s_hready_resp[0]); end
    next_cycle();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    #2;
    checks++; if (m_htrans !== 2'b00) begin errors++; $display("FAIL stall_c5_idle: got %b expected 00", m_htrans); end
    next_cycle();
  endtask

  task automatic test_error();
    set_port(0, 2'b10, 32'h8, 1'b1, 1'b1);
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    #2;
    checks++; if (m_hwrite !== 1'b1 || m_haddr !== 32'h8) begin errors++; $display("FAIL err_aphase: got %b/%h expected 1/00000008", m_hwrite, m_haddr); end
    next_cycle();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    m_hresp = 1'b1; m_hready_resp = 1'b0;
    #2;
    checks++; if (s_hresp !== 2'b01 || s_hready_resp !== 2'b10) begin errors++; $display("FAIL err_c1: got resp %b rdy %b expected 01/10", s_hresp, s_hready_resp); end
    next_cycle();
    m_hready_resp = 1'b1;
    #2;
    checks++; if (s_hresp !== 2'b01 || s_hready_resp !== 2'b11) begin errors++; $display("FAIL err_c2: got resp %b rdy %b expected 01/11", s_hresp, s_hready_resp); end
    next_cycle();
    m_hresp = 1'b0;
    #2;
    checks++; if (s_hresp !== 2'b00) begin errors++; $display("FAIL err_after: got %b expected 00", s_hresp); end
    next_cycle();
  endtask

  task automatic test_wdata();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h30, 1'b1, 1'b1);
    next_cycle();
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    s_hwdata = {32'hdeadbeef, 32'h12345678};
    #2;
    checks++; if (m_hwdata !== 32'hdeadbeef) begin errors++; $display("FAIL wdata_port1: got %h expected deadbeef", m_hwdata); end
    next_cycle();
    s_hwdata = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_port(0, 2'b10, 32'h50, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h60, 1'b0, 1'b1);
    next_cycle();
    set_port(0, 2'b00, 32'h0, 1'b0, 1'b1);
    set_port(1, 2'b10, 32'h60, 1'b0, 1'b0);
    #2;
    checks++; if (m_haddr !== 32'h60 || s_hready_resp[1] !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got %h/%b expected 00000060/0", m_haddr, s_hready_resp[1]); end
    rst_n = 1'b0;
    set_port(1, 2'b00, 32'h0, 1'b0, 1'b1);
    #1;
    checks++; if (m_htrans !== 2'b00 || s_hready_resp !== 2'b11) begin errors++; $display("FAIL rstmid_assert: got %b/%b expected 00/11", m_htrans, s_hready_resp); end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      #2;
      checks++; if (m_htrans !== 2'b00 || s_hready_resp !== 2'b11) begin errors++; $display("FAIL rstmid_after%0d: got %b/%b expected 00/11", k, m_htrans, s_hready_resp); end
    end
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_simultaneous();
    test_stall();
    test_error();
    test_wdata();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_arbiter.md
Name: ahbl_arbiter

Overview:
AHB-lite N:1 arbiter. It merges several AHB-lite masters onto one downstream slave port, which is the inverse of the 1:N splitter. Each upstream port gets a one-transfer address-phase buffer, so a losing master's transfer is captured and replayed later rather than lost. It sits below CPU/DMA/display masters, in front of shared slaves such as SRAM or the peripheral splitter.

Parameters:
N_PORTS, 2, number of upstream master ports; index 0 has highest priority.
W_ADDR, 32, address width.
W_DATA, 32, data width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ahbls_hready  input  N_PORTS  per-port upstream bus hready
ahbls_hready_resp  output  N_PORTS  per-port hready response to master
ahbls_hresp  output  N_PORTS  per-port error response
ahbls_haddr  input  N_PORTS*W_ADDR  per-port address
ahbls_hwrite  input  N_PORTS  per-port write flag
ahbls_htrans  input  N_PORTS*2  per-port transfer type
ahbls_hsize  input  N_PORTS*3  per-port size
ahbls_hburst  input  N_PORTS*3  per-port burst type
ahbls_hprot  input  N_PORTS*4  per-port protection
ahbls_hmastlock  input  N_PORTS  per-port lock
ahbls_hwdata  input  N_PORTS*W_DATA  per-port write data
ahbls_hrdata  output  N_PORTS*W_DATA  per-port read data
ahblm_hready  output  1  downstream hready; equals ahblm_hready_resp
ahblm_hready_resp  input  1  downstream slave hready response
ahblm_hresp  input  1  downstream error response
ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot, ahblm_hmastlock  output  W_ADDR/1/2/3/3/4/1  downstream address-phase signals
ahblm_hwdata  output  W_DATA  downstream write data
ahblm_hrdata  input  W_DATA  downstream read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Live request, port i: ahbls_hready[i] && ahbls_htrans[i][1] && !buf_valid[i].
- Effective request: req[i] = buf_valid[i] || live request[i].
- Buffer contents, per port: buf_valid plus haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock.
- While buf_valid[i]=1, the live port i bus is ignored. The master is stalled holding its next address.
- Address-phase grant grant_a is one-hot:
  - if hold_valid, grant_a = hold_grant;
  - otherwise, the lowest-index set bit of req;
  - zero if there are no requests.
- Downstream address mux:
  - signals come from the buffer if buf_valid for the granted port, else from the live port;
  - ahblm_htrans = IDLE (2'b00) when grant_a = 0;
  - other downstream address signals are don't-care while IDLE.
- Accept: a transfer is accepted downstream when grant_a[i] && ahblm_hready.
- Buffer fill: a live request that is not accepted in the same cycle is latched into buffer i (buf_valid[i] <= 1). This covers losing arbitration and downstream stall.
- Buffer clear: buf_valid[i] clears on acceptance of the buffered transfer. Fill and clear never coincide for one port.
- Address hold: if ahblm_hready=0 and grant_a≠0, set hold_valid <= 1 and hold_grant <= grant_a. Clear hold_valid when ahblm_hready=1. A stalled NONSEQ therefore never changes address, even if a higher-priority request arrives.
- Data-phase owner: grant_d <= grant_a when ahblm_hready=1; otherwise it holds.
- ahbls_hready_resp[i] = grant_d[i] ? ahblm_hready_resp : !buf_valid[i].
- ahbls_hresp[i] = grant_d[i] & ahblm_hresp.
- ahbls_hrdata: downstream hrdata broadcast to all ports.
- ahblm_hwdata: muxed by grant_d.
- Latency: an uncontended transfer has zero added cycles. A buffered transfer waits at least one extra cycle; the master sees hready_resp=0 until it completes.
- Two-cycle error response: passes to the owner unchanged. Non-owners see hresp=0.
- Locking: hmastlock is passed through only. Locked sequences are not honoured by arbitration.
- Bursts: each beat is arbitrated independently. SEQ beats are forwarded as presented; a burst may be interleaved with other masters' transfers.
- Reset values:
  - buf_valid=0, hold_valid=0, grant_d=0;
  - ahblm_htrans=IDLE;
  - ahbls_hready_resp all 1, ahbls_hresp all 0.
- Reset mid-operation: buffered transfers are discarded.

Decomposition:
- HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) go in the shared AHB definitions include, reused by the splitter.
- One sub-module, onehot_priority (N-bit lowest-index-wins), is natural.
- Data-phase muxes reuse the existing bitmap_mux.

Test Plan:
- Uncontended read: port0 NONSEQ read 0x100, others idle.
  -> ahblm_htrans=NONSEQ and haddr=0x100 in the same cycle.
  -> ahbls_hrdata[0] equals ahblm_hrdata; hready_resp[0] follows downstream.
- Simultaneous requests: port0 0x10 and port1 0x20 in cycle 0.
  -> cycle 0: downstream 0x10; port1 buffered.
  -> cycle 1: downstream 0x20 from buffer; hready_resp[1]=0.
  -> cycle 2: hready_resp[1] follows downstream.
- Downstream stall: port1 0x40 presented while ahblm_hready_resp=0 for 3 cycles, and port0 requests 0x80 mid-stall.
  -> haddr stays 0x40 throughout the stall.
  -> 0x80 is issued in the first cycle after hready.
- Error: slave returns two-cycle ERROR on port0 write 0x8.
  -> port0 sees hresp=1 with hready_resp 0 then 1.
  -> idle port1 sees hresp=0 and hready_resp=1.
- Write data routing: port1 writes 0xdeadbeef while port0 drives 0x12345678 on its hwdata.
  -> ahblm_hwdata=0xdeadbeef during port1's data phase.
- Reset with buf_valid[1]=1: assert rst_n low.
  -> htrans=IDLE, hready_resp all 1; the buffered transfer is never issued.
